sweep_tracker: RTL and testbench
================================

Name: sweep_tracker

Overview:
Single-axis sweep-and-seek controller that sits directly upstream of servo_driver. It drives servo_driver's BTN_0/BTN_1 direction inputs and ES sweep-enable input. It reads back servo_position and PWM_limit, plus a light-intensity sample stream from the ADC front end. On START it homes the servo, sweeps it across its full range while recording the brightest position, then returns to that position and reports it.

Parameters:
POS_W, 32, width of servo position (pulse width, in inter_clk ticks)
LIGHT_W, 12, width of light sample
POS_MIN, 500, home position; homing ends when SERVO_POS <= POS_MIN
TOL, 4, return tolerance window around best position
TIMEOUT, 50_000_000, max CLK cycles per active state before abort

Ports:
CLK  in  1  system clock (100 MHz)
RST  in  1  reset, asynchronous assert, active-low
START  in  1  single-cycle request to begin a track cycle
ABORT  in  1  force return to IDLE
LIGHT  in  LIGHT_W  light sample
LIGHT_VALID  in  1  LIGHT qualifier, one-cycle strobe
SERVO_POS  in  POS_W  current pulse width from servo_driver
PWM_LIMIT  in  1  servo_driver upper-limit flag
BTN_0  out  1  CCW request (decreases pulse width)
BTN_1  out  1  CW request (increases pulse width)
ES  out  1  sweep enable to servo_driver
BUSY  out  1  high in any state other than IDLE
DONE  out  1  one-cycle pulse on successful completion
ERR  out  1  sticky timeout flag; cleared by next accepted START or reset
BEST_POS  out  POS_W  position of maximum light from last completed sweep
BEST_LIGHT  out  LIGHT_W  maximum light value from last completed sweep

Behaviour:
- Reset values: all outputs 0; state IDLE; internal best registers 0; timer 0.
- All outputs are registered. BTN_0/BTN_1/ES change one cycle after the state transition. BTN_0 and BTN_1 are never both 1.
- IDLE: BTN_0=BTN_1=ES=0.
  - START=1 -> HOME; clear ERR, cur_best_light=0, cur_best_pos=SERVO_POS.
  - START while BUSY is ignored.
- HOME: BTN_0=1, ES=1.
  - SERVO_POS <= POS_MIN -> SWEEP.
- SWEEP: BTN_1=1, ES=1.
  - Each LIGHT_VALID: if LIGHT > cur_best_light (strictly greater, so ties keep the earliest position), latch cur_best_light=LIGHT and cur_best_pos=SERVO_POS in the same cycle.
  - PWM_LIMIT=1 -> RETURN. A LIGHT_VALID in the exit cycle is still evaluated.
- RETURN: BTN_0=1, ES=0.
  - SERVO_POS <= cur_best_pos + TOL -> SETTLE. Compare at POS_W+1 bits; no wrap.
- SETTLE: outputs stop for one cycle.
  - Copy cur_best_* to BEST_POS/BEST_LIGHT, pulse DONE, then -> IDLE.
- LIGHT_VALID outside SWEEP is ignored.
- Timer: reset to 0 on every state entry; increments in HOME/SWEEP/RETURN. Reaching TIMEOUT-1 -> IDLE, ERR=1, no DONE, BEST_* unchanged.
- ABORT has priority over START, timeout and normal transitions. Any state -> IDLE next cycle, no DONE, ERR unchanged, BEST_* unchanged.
- RST asserted mid-operation: immediate return to reset values, including BEST_*.
- Simultaneous PWM_LIMIT and timeout in SWEEP: timeout wins.
- If SERVO_POS <= POS_MIN already on HOME entry, HOME lasts exactly one cycle.

Decomposition:
- Shared package: state encoding (IDLE, HOME, SWEEP, RETURN, SETTLE as 3-bit localparams) and direction codes matching servo_driver (00 stop, 01 CCW, 10 CW).
- One sub-module: sweep_peak_tracker (compare/latch of LIGHT vs best, with clear and enable inputs).
- Timer stays inline.

Test Plan:
1. Reset, then START with behavioural servo model (pos starts 900, ±1 per 2 CLK) -> BTN_0=1 until pos=500; BTN_1=1 until PWM_LIMIT at 700; BUSY=1 throughout.
2. LIGHT=100@pos 550, 300@620, 300@640, 200@680 -> BEST_LIGHT=300, BEST_POS=620 (tie keeps first), DONE one cycle after pos <= 624.
3. TIMEOUT=1000 with servo model frozen at pos 800 -> HOME times out, IDLE at cycle 1000, ERR=1, DONE=0, BEST_* unchanged; next START clears ERR.
4. ABORT asserted during SWEEP with START the same cycle -> IDLE next cycle, BTN_0=BTN_1=ES=0, START ignored, no DONE.
5. START pulsed again mid-SWEEP -> no restart, cur_best values unchanged, single DONE at end.
6. RST low mid-RETURN -> all outputs 0 asynchronously; after RST high, START runs a full cycle normally.

Source files
------------

// File: rtl/sweep_tracker_pkg.sv
// Shared state encoding and servo_driver direction codes for the sweep tracker.
package sweep_tracker_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_HOME   = 3'd1;
  localparam logic [2:0] ST_SWEEP  = 3'd2;
  localparam logic [2:0] ST_RETURN = 3'd3;
  localparam logic [2:0] ST_SETTLE = 3'd4;

  // dir[0] drives BTN_0 (CCW), dir[1] drives BTN_1 (CW); one-hot or zero only
  localparam logic [1:0] DIR_STOP = 2'b00;
  localparam logic [1:0] DIR_CCW  = 2'b01;
  localparam logic [1:0] DIR_CW   = 2'b10;

  typedef struct packed {
    logic [1:0] dir;
    logic       es;
  } drive_t;

  function automatic drive_t state_drive(input logic [2:0] st);
    drive_t d;
    d = '{dir: DIR_STOP, es: 1'b0};
    case (st)
      ST_HOME:   d = '{dir: DIR_CCW, es: 1'b1};
      ST_SWEEP:  d = '{dir: DIR_CW,  es: 1'b1};
      ST_RETURN: d = '{dir: DIR_CCW, es: 1'b0};
      default:   d = '{dir: DIR_STOP, es: 1'b0};
    endcase
    return d;
  endfunction

endpackage

// File: rtl/sweep_peak_tracker.sv
// Running maximum of the light stream, remembering the servo position of the peak.
module sweep_peak_tracker #(
  parameter int POS_W   = 32,
  parameter int LIGHT_W = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               en,
  input  logic [LIGHT_W-1:0] light,
  input  logic [POS_W-1:0]   pos,
  output logic [LIGHT_W-1:0] best_light,
  output logic [POS_W-1:0]   best_pos
);

  logic [LIGHT_W-1:0] best_light_q, best_light_d;
  logic [POS_W-1:0]   best_pos_q, best_pos_d;

  // Strict compare: equal samples keep the earliest position
  always_comb begin
    best_light_d = best_light_q;
    best_pos_d   = best_pos_q;
    if (clr) begin
      best_light_d = '0;
      best_pos_d   = pos;
    end else if (en && (light > best_light_q)) begin
      best_light_d = light;
      best_pos_d   = pos;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best_light_q <= '0;
      best_pos_q   <= '0;
    end else begin
      best_light_q <= best_light_d;
      best_pos_q   <= best_pos_d;
    end
  end

  assign best_light = best_light_q;
  assign best_pos   = best_pos_q;

endmodule

// File: rtl/sweep_tracker.sv
// Home / sweep / return-to-peak controller sitting in front of servo_driver.
module sweep_tracker
  import sweep_tracker_pkg::*;
#(
  parameter int POS_W   = 32,
  parameter int LIGHT_W = 12,
  parameter int POS_MIN = 500,
  parameter int TOL     = 4,
  parameter int TIMEOUT = 50_000_000
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               START,
  input  logic               ABORT,
  input  logic [LIGHT_W-1:0] LIGHT,
  input  logic               LIGHT_VALID,
  input  logic [POS_W-1:0]   SERVO_POS,
  input  logic               PWM_LIMIT,
  output logic               BTN_0,
  output logic               BTN_1,
  output logic               ES,
  output logic               BUSY,
  output logic               DONE,
  output logic               ERR,
  output logic [POS_W-1:0]   BEST_POS,
  output logic [LIGHT_W-1:0] BEST_LIGHT
);

  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  logic [2:0]         state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  drive_t             drive_q, drive_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [POS_W-1:0]   best_pos_q, best_pos_d;
  logic [LIGHT_W-1:0] best_light_q, best_light_d;

  logic               start_acc, active, timed_out, peak_en;
  logic [POS_W-1:0]   cur_best_pos;
  logic [LIGHT_W-1:0] cur_best_light;
  logic [POS_W:0]     ret_tgt;

  assign active    = (state_q == ST_HOME) || (state_q == ST_SWEEP) || (state_q == ST_RETURN);
  assign timed_out = active && (timer_q == TMR_LAST);
  assign peak_en   = (state_q == ST_SWEEP) && LIGHT_VALID;
  // One extra bit so a peak near the top of the range cannot wrap the target
  assign ret_tgt   = {1'b0, cur_best_pos} + (POS_W+1)'(TOL);

  sweep_peak_tracker #(.POS_W(POS_W), .LIGHT_W(LIGHT_W)) u_peak (
    .clk        (CLK),
    .rst_n      (RST),
    .clr        (start_acc),
    .en         (peak_en),
    .light      (LIGHT),
    .pos        (SERVO_POS),
    .best_light (cur_best_light),
    .best_pos   (cur_best_pos)
  );

  always_comb begin
    state_d      = state_q;
    err_d        = err_q;
    done_d       = 1'b0;
    best_pos_d   = best_pos_q;
    best_light_d = best_light_q;
    start_acc    = 1'b0;
    if (ABORT) begin
      state_d = ST_IDLE;
    end else if (timed_out) begin
      state_d = ST_IDLE;
      err_d   = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: if (START) begin
          state_d   = ST_HOME;
          err_d     = 1'b0;
          start_acc = 1'b1;
        end
        ST_HOME:   if (SERVO_POS <= POS_W'(POS_MIN)) state_d = ST_SWEEP;
        ST_SWEEP:  if (PWM_LIMIT) state_d = ST_RETURN;
        ST_RETURN: if ({1'b0, SERVO_POS} <= ret_tgt) state_d = ST_SETTLE;
        ST_SETTLE: begin
          state_d      = ST_IDLE;
          done_d       = 1'b1;
          best_pos_d   = cur_best_pos;
          best_light_d = cur_best_light;
        end
        default:   state_d = ST_IDLE;
      endcase
    end
    // Timer restarts on any state change and only runs in the motion states
    if (state_d != state_q) timer_d = '0;
    else if (active)        timer_d = timer_q + TMR_W'(1);
    else                    timer_d = timer_q;
    drive_d = state_drive(state_d);
    busy_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= ST_IDLE;
      timer_q      <= '0;
      drive_q      <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      best_pos_q   <= '0;
      best_light_q <= '0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      drive_q      <= drive_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      best_pos_q   <= best_pos_d;
      best_light_q <= best_light_d;
    end
  end

  assign BTN_0      = drive_q.dir[0];
  assign BTN_1      = drive_q.dir[1];
  assign ES         = drive_q.es;
  assign BUSY       = busy_q;
  assign DONE       = done_q;
  assign ERR        = err_q;
  assign BEST_POS   = best_pos_q;
  assign BEST_LIGHT = best_light_q;

endmodule

// File: tb/tb_sweep_tracker.sv
// Directed bench for sweep_tracker with a behavioural servo and a DONE scoreboard.
module tb_sweep_tracker;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        START = 1'b0;
  logic        ABORT = 1'b0;
  logic [11:0] LIGHT = '0;
  logic        LIGHT_VALID = 1'b0;
  logic [31:0] pos = 32'd900;
  logic        PWM_LIMIT;
  logic        BTN_0, BTN_1, ES, BUSY, DONE, ERR;
  logic [31:0] BEST_POS;
  logic [11:0] BEST_LIGHT;

  logic        pos_ld = 1'b0;
  logic [31:0] pos_ld_val = '0;
  logic        freeze = 1'b0;
  logic        div = 1'b0;
  logic [3:0]  sent = '0;

  localparam int LP [4] = '{550, 620, 640, 680};
  localparam int LV [4] = '{100, 300, 300, 200};

  typedef struct { logic [11:0] l; logic [31:0] p; } exp_t;
  exp_t sb[$];
  int total = 0, bad = 0, done_cnt = 0;

  sweep_tracker #(.POS_W(32), .LIGHT_W(12), .POS_MIN(500), .TOL(4), .TIMEOUT(1000)) dut (
    .CLK(CLK), .RST(RST), .START(START), .ABORT(ABORT), .LIGHT(LIGHT),
    .LIGHT_VALID(LIGHT_VALID), .SERVO_POS(pos), .PWM_LIMIT(PWM_LIMIT),
    .BTN_0(BTN_0), .BTN_1(BTN_1), .ES(ES), .BUSY(BUSY), .DONE(DONE), .ERR(ERR),
    .BEST_POS(BEST_POS), .BEST_LIGHT(BEST_LIGHT)
  );

  always #5 CLK = ~CLK;

  // Servo: one tick per two clocks in the requested direction, range 0..700
  assign PWM_LIMIT = (pos >= 32'd700);
  always @(posedge CLK) begin
    if (pos_ld) pos <= pos_ld_val;
    else if (!freeze) begin
      div <= ~div;
      if (div) begin
        if (BTN_0 && pos > 0)          pos <= pos - 1;
        else if (BTN_1 && pos < 700)   pos <= pos + 1;
      end
    end
  end

  // Light samples fire once per position while sweeping
  always @(negedge CLK) begin
    LIGHT_VALID <= 1'b0;
    if (BTN_0) sent <= '0;
    else if (BTN_1)
      for (int i = 0; i < 4; i++)
        if (pos == LP[i] && !sent[i]) begin
          LIGHT_VALID <= 1'b1;
          LIGHT       <= 12'(LV[i]);
          sent[i]     <= 1'b1;
        end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    exp_t e;
    @(negedge CLK);
    total++;
    assert (!(BTN_0 && BTN_1)) else begin
      bad++;
      $error("FAIL btn_excl observed=%b%b expected=not_both", BTN_1, BTN_0);
    end
    if (DONE === 1'b1) begin
      done_cnt++;
      total++;
      assert (sb.size() > 0) else begin
        bad++;
        $error("FAIL unexpected_done observed=1 expected=0");
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("sb_best_light", 64'(BEST_LIGHT), 64'(e.l));
        chk("sb_best_pos", 64'(BEST_POS), 64'(e.p));
      end
    end
  endtask

  function automatic logic sigsel(input int sel);
    case (sel)
      0: return BTN_0;
      1: return BTN_1;
      2: return BUSY;
      default: return DONE;
    endcase
  endfunction

  task automatic wait_on(input int sel, input logic v, input int bound, input string tag);
    int n = 0;
    while (sigsel(sel) !== v && n < bound) begin
      cyc();
      n++;
    end
    chk(tag, 64'(n < bound), 64'd1);
  endtask

  task automatic load_pos(input logic [31:0] p);
    pos_ld_val = p;
    pos_ld = 1'b1;
    cyc();
    pos_ld = 1'b0;
  endtask

  initial begin
    int n, dc;
    exp_t e0;
    e0.l = 12'd300;
    e0.p = 32'd620;
    repeat (3) cyc();
    chk("rst_outs", 64'({BUSY, DONE, ERR, BTN_0, BTN_1, ES}), 64'd0);
    chk("rst_best", 64'({BEST_POS, BEST_LIGHT}), 64'd0);
    RST = 1'b1;
    load_pos(32'd900);
    cyc();

    // full track cycle from 900
    START = 1'b1; sb.push_back(e0); cyc(); START = 1'b0;
    chk("t1_home_drv", 64'({BUSY, BTN_0, BTN_1, ES}), 64'b1101);
    wait_on(1, 1'b1, 2000, "t1_sweep_wait");
    chk("t1_home_end", 64'(pos <= 500 && pos >= 499), 64'd1);
    chk("t1_sweep_drv", 64'({BUSY, BTN_0, BTN_1, ES}), 64'b1011);
    wait_on(0, 1'b1, 2000, "t1_return_wait");
    chk("t1_limit_pos", 64'(pos), 64'd700);
    chk("t1_return_drv", 64'({BUSY, BTN_0, BTN_1, ES}), 64'b1100);
    dc = done_cnt;
    wait_on(3, 1'b1, 1000, "t2_done_wait");
    chk("t2_done_pos", 64'(pos >= 622 && pos <= 624), 64'd1);
    chk("t2_done_cnt", 64'(done_cnt - dc), 64'd1);
    cyc();
    chk("t2_done_pulse", 64'({DONE, BUSY, ERR}), 64'd0);

    // timeout in HOME with a frozen servo
    freeze = 1'b1;
    load_pos(32'd800);
    START = 1'b1; cyc(); START = 1'b0;
    n = 0;
    while (BUSY && n < 3000) begin n++; cyc(); end
    chk("t3_home_cycles", 64'(n), 64'd1000);
    chk("t3_err_set", 64'({ERR, DONE, BTN_0, ES}), 64'b1000);
    chk("t3_best_kept", 64'({BEST_POS, BEST_LIGHT}), {20'd0, 32'd620, 12'd300});

    // abort during SWEEP with START in the same cycle
    freeze = 1'b0;
    START = 1'b1; cyc(); START = 1'b0;
    chk("t4_err_clr", 64'({ERR, BUSY}), 64'b01);
    wait_on(1, 1'b1, 2000, "t4_sweep_wait");
    repeat (5) cyc();
    ABORT = 1'b1; START = 1'b1; cyc(); ABORT = 1'b0; START = 1'b0;
    chk("t4_abort", 64'({BUSY, BTN_0, BTN_1, ES, DONE}), 64'd0);
    repeat (10) cyc();
    chk("t4_idle_hold", 64'({BUSY, ERR}), 64'd0);
    chk("t4_best_kept", 64'({BEST_POS, BEST_LIGHT}), {20'd0, 32'd620, 12'd300});

    // START mid-SWEEP is ignored
    load_pos(32'd900);
    START = 1'b1; sb.push_back(e0); cyc(); START = 1'b0;
    wait_on(1, 1'b1, 2000, "t5_sweep_wait");
    n = 0;
    while (pos != 650 && n < 2000) begin cyc(); n++; end
    chk("t5_reach650", 64'(n < 2000), 64'd1);
    START = 1'b1; cyc(); START = 1'b0;
    chk("t5_no_restart", 64'({BUSY, BTN_0, BTN_1}), 64'b101);
    dc = done_cnt;
    wait_on(3, 1'b1, 2000, "t5_done_wait");
    repeat (300) cyc();
    chk("t5_single_done", 64'(done_cnt - dc), 64'd1);

    // asynchronous reset mid-RETURN, then a clean run
    load_pos(32'd900);
    START = 1'b1; cyc(); START = 1'b0;
    wait_on(1, 1'b1, 2000, "t6_sweep_wait");
    wait_on(0, 1'b1, 2000, "t6_return_wait");
    repeat (20) cyc();
    #2 RST = 1'b0;
    #1;
    chk("t6_rst_outs", 64'({BUSY, DONE, ERR, BTN_0, BTN_1, ES}), 64'd0);
    chk("t6_rst_best", 64'({BEST_POS, BEST_LIGHT}), 64'd0);
    cyc();
    RST = 1'b1;
    load_pos(32'd900);
    START = 1'b1; sb.push_back(e0); cyc(); START = 1'b0;
    dc = done_cnt;
    wait_on(3, 1'b1, 3000, "t6_done_wait");
    chk("t6_done_cnt", 64'(done_cnt - dc), 64'd1);

    // already at home: HOME lasts exactly one cycle
    load_pos(32'd450);
    START = 1'b1; sb.push_back(e0); cyc(); START = 1'b0;
    chk("t7_home_one", 64'({BTN_0, BTN_1}), 64'b10);
    cyc();
    chk("t7_sweep_next", 64'({BTN_0, BTN_1}), 64'b01);
    wait_on(3, 1'b1, 3000, "t7_done_wait");
    cyc();
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
